// File: rtl/risc_intc.sv
// Multi-source vectored interrupt controller: synchronised, edge-latched, maskable channels
// arbitrated by fixed priority (lowest index wins). Optional level mode under RISC_INTC_LEVEL_EN.
module risc_intc #(
  parameter int unsigned       N_IRQ      = 4,
  parameter int unsigned       VEC_W      = 16,
  parameter logic [VEC_W-1:0]  BASE_VEC   = 16'h0100,
  parameter int unsigned       VEC_STRIDE = 4,
  parameter int unsigned       OVF_W      = 8,
  localparam int unsigned      ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
`ifdef RISC_INTC_LEVEL_EN
  input  logic             mode_sel,
`endif
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic [N_IRQ-1:0] mask_q,
  output logic [N_IRQ-1:0] pend_q,
  output logic             int_req,
  input  logic             int_ack,
  input  logic             int_done,
  output logic [VEC_W-1:0] int_vec,
  output logic [ID_W-1:0]  int_id,
  output logic             busy,
  output logic [OVF_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t             state, state_n;
  logic [N_IRQ-1:0]   s1, s2, s3;
  logic [N_IRQ-1:0]   rise, clr, lost, elig, pend_n;
  logic [ID_W-1:0]    win, id_n;
  logic [VEC_W-1:0]   vec_n;
  logic               req_n, busy_n;
  logic [4:0]         lost_n;
  logic [OVF_W+4:0]   ovf_sum;
`ifdef RISC_INTC_LEVEL_EN
  logic [N_IRQ-1:0]   mode_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign elig = pend_q & mask_q;

  always_comb begin
    clr = '0;
    if (state == REQ && int_ack) clr[int_id] = 1'b1;
    pend_n = (pend_q & ~clr) | rise;
    lost   = rise & pend_q;
`ifdef RISC_INTC_LEVEL_EN
    // Level channels mirror the synchronised line and never count overruns.
    pend_n = (pend_n & ~mode_q) | (s2 & mode_q);
    lost   = lost & ~mode_q;
`endif
    lost_n = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) lost_n = lost_n + 5'(lost[i]);
    ovf_sum = (OVF_W+5)'(ovf_cnt) + (OVF_W+5)'(lost_n);
  end

  always_comb begin
    win = '0;
    for (int unsigned i = N_IRQ; i > 0; i--)
      if (elig[i-1]) win = ID_W'(i-1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q  <= '0;
      pend_q  <= '0;
      ovf_cnt <= '0;
`ifdef RISC_INTC_LEVEL_EN
      mode_q  <= '0;
`endif
    end else begin
`ifdef RISC_INTC_LEVEL_EN
      if (mask_we && mode_sel)  mode_q <= mask_wdata;
      if (mask_we && !mode_sel) mask_q <= mask_wdata;
`else
      if (mask_we) mask_q <= mask_wdata;
`endif
      pend_q <= pend_n;
      if (ovf_clr)                         ovf_cnt <= '0;
      else if (|ovf_sum[OVF_W+4:OVF_W])    ovf_cnt <= '1;
      else                                 ovf_cnt <= ovf_sum[OVF_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      int_req <= 1'b0;
      busy    <= 1'b0;
      int_id  <= '0;
      int_vec <= BASE_VEC;
    end else begin
      state   <= state_n;
      int_req <= req_n;
      busy    <= busy_n;
      int_id  <= id_n;
      int_vec <= vec_n;
    end
  end

  always_comb begin
    state_n = state;
    req_n   = int_req;
    busy_n  = busy;
    id_n    = int_id;
    vec_n   = int_vec;
    case (state)
      IDLE: if (|elig) begin
        id_n    = win;
        vec_n   = BASE_VEC + VEC_W'(win) * VEC_W'(VEC_STRIDE);
        req_n   = 1'b1;
        state_n = REQ;
      end
      REQ: if (int_ack) begin
        req_n   = 1'b0;
        busy_n  = 1'b1;
        state_n = SERV;
      end
      SERV: if (int_done) begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc_intc.sv
// Directed bench for risc_intc: expected (id, vector) pairs are queued as stimulus is driven
// and popped when the controller raises int_req.
module tb_risc_intc;

  localparam int unsigned N_IRQ = 4;
  localparam int unsigned VEC_W = 16;
  localparam int unsigned OVF_W = 8;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] vec;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_IRQ-1:0] irq_in = '0;
  logic             mask_we = 1'b0;
  logic [N_IRQ-1:0] mask_wdata = '0;
  logic [N_IRQ-1:0] mask_q, pend_q;
  logic             int_req, busy;
  logic             int_ack = 1'b0;
  logic             int_done = 1'b0;
  logic [VEC_W-1:0] int_vec;
  logic [1:0]       int_id;
  logic [OVF_W-1:0] ovf_cnt;
  logic             ovf_clr = 1'b0;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  risc_intc #(
    .N_IRQ(N_IRQ), .VEC_W(VEC_W), .BASE_VEC(16'h0100), .VEC_STRIDE(4), .OVF_W(OVF_W)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .mask_q(mask_q), .pend_q(pend_q),
    .int_req(int_req), .int_ack(int_ack), .int_done(int_done),
    .int_vec(int_vec), .int_id(int_id), .busy(busy),
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ch);
    irq_in[ch] = 1'b1;
    step(2);
    irq_in[ch] = 1'b0;
    step(2);
  endtask

  task automatic write_mask(input logic [N_IRQ-1:0] m);
    mask_wdata = m;
    mask_we    = 1'b1;
    step(1);
    mask_we    = 1'b0;
    chk("mask_q", 32'(mask_q), 32'(m));
  endtask

  task automatic push(input logic [1:0] id, input logic [15:0] vec);
    exp_t e;
    e.id  = id;
    e.vec = vec;
    sb.push_back(e);
  endtask

  task automatic wait_req(input string tag);
    int c = 0;
    while (int_req !== 1'b1 && c < 20) begin
      step(1);
      c++;
    end
    chk({tag, "_req"}, 32'(int_req), 32'd1);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) e = sb.pop_front();
    chk({tag, "_id"}, 32'(int_id), 32'(e.id));
    chk({tag, "_vec"}, 32'(int_vec), 32'(e.vec));
  endtask

  task automatic serve(input string tag);
    pop_cmp(tag);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    chk({tag, "_req_drop"}, 32'(int_req), 32'd0);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_idle_gap"}, 32'(int_req), 32'd0);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_mask", 32'(mask_q), 32'd0);
    chk("rst_pend", 32'(pend_q), 32'd0);
    chk("rst_req", 32'(int_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vec", 32'(int_vec), 32'h0100);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);

    // Single channel, latency check
    write_mask(4'b0001);
    push(2'd0, 16'h0100);
    irq_in[0] = 1'b1;
    step(2);
    irq_in[0] = 1'b0;
    step(1);
    chk("t1_pend_e3", 32'(pend_q), 32'b0001);
    chk("t1_req_e3", 32'(int_req), 32'd0);
    step(1);
    chk("t1_req_e4", 32'(int_req), 32'd1);
    pop_cmp("t1");
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    chk("t1_pend_ack", 32'(pend_q), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    chk("t1_busy_done", 32'(busy), 32'd0);

    // Two simultaneous channels: priority then one idle cycle
    write_mask(4'b1111);
    push(2'd1, 16'h0104);
    push(2'd3, 16'h010C);
    irq_in = 4'b1010;
    wait_req("t2a");
    irq_in = 4'b0000;
    serve("t2a");
    step(1);
    chk("t2b_req", 32'(int_req), 32'd1);
    serve("t2b");

    // Overruns and saturation
    write_mask(4'b0100);
    push(2'd2, 16'h0108);
    pulse(2);
    pulse(2);
    pulse(2);
    step(3);
    chk("t3_ovf2", 32'(ovf_cnt), 32'd2);
    wait_req("t3");
    serve("t3");
    step(3);
    chk("t3_single_req", 32'(int_req), 32'd0);
    chk("t3_pend_clear", 32'(pend_q), 32'd0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(ovf_cnt), 32'd0);
    write_mask(4'b0000);
    for (int i = 0; i < 301; i++) pulse(2);
    step(3);
    chk("t3_ovf_sat", 32'(ovf_cnt), 32'd255);
    chk("t3_masked_pend", 32'(pend_q), 32'b0100);
    chk("t3_masked_req", 32'(int_req), 32'd0);
    push(2'd2, 16'h0108);
    write_mask(4'b0100);
    wait_req("t3s");
    serve("t3s");
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t3_ovf_clr2", 32'(ovf_cnt), 32'd0);

    // Masked pending becomes eligible on unmask
    write_mask(4'b0000);
    pulse(1);
    step(2);
    chk("t4_pend", 32'(pend_q), 32'b0010);
    chk("t4_req_masked", 32'(int_req), 32'd0);
    push(2'd1, 16'h0104);
    mask_wdata = 4'b0010;
    mask_we    = 1'b1;
    step(1);
    mask_we    = 1'b0;
    chk("t4_req_e1", 32'(int_req), 32'd0);
    step(1);
    chk("t4_req_e2", 32'(int_req), 32'd1);
    serve("t4");

    // Edge coincident with ack: set wins
    write_mask(4'b0100);
    push(2'd2, 16'h0108);
    push(2'd2, 16'h0108);
    pulse(2);
    wait_req("t5a");
    pop_cmp("t5a");
    irq_in[2] = 1'b1;
    step(2);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    irq_in[2] = 1'b0;
    chk("t5_pend_kept", 32'(pend_q), 32'b0100);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_req_drop", 32'(int_req), 32'd0);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    chk("t5_idle_gap", 32'(int_req), 32'd0);
    step(1);
    chk("t5b_req", 32'(int_req), 32'd1);
    serve("t5b");

    // Reset during REQ
    write_mask(4'b1111);
    irq_in = 4'b1010;
    step(2);
    irq_in = 4'b0000;
    wait_req("t6");
    chk("t6_id_pre", 32'(int_id), 32'd1);
    chk("t6_pend_pre", 32'(pend_q), 32'b1010);
    rst = 1'b1;
    #1;
    chk("t6_rst_mask", 32'(mask_q), 32'd0);
    chk("t6_rst_pend", 32'(pend_q), 32'd0);
    chk("t6_rst_req", 32'(int_req), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_id", 32'(int_id), 32'd0);
    chk("t6_rst_vec", 32'(int_vec), 32'h0100);
    chk("t6_rst_ovf", 32'(ovf_cnt), 32'd0);
    step(2);
    rst = 1'b0;
    write_mask(4'b1111);
    step(10);
    chk("t6_no_req", 32'(int_req), 32'd0);
    chk("t6_no_pend", 32'(pend_q), 32'd0);
    push(2'd3, 16'h010C);
    pulse(3);
    wait_req("t6n");
    serve("t6n");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
